// File: rtl/fir_pkg.sv
// fir_pkg: shared state type and parameter derivations for the multi-channel FIR engine.
package fir_pkg;
   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
   function automatic int clog2(input int n);
      int r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction
   function automatic int chw(input int nch);
      return nch > 1 ? clog2(nch) : 1;
   endfunction
   function automatic int acc_w(input int w, input int cw, input int nt);
      return w + cw + clog2(nt);
   endfunction
   // Tap 0 powers up at unity gain, every other tap at zero.
   function automatic int coef_rst(input int tap, input int frac);
      return tap == 0 ? 1 << frac : 0;
   endfunction
endpackage

// File: rtl/fir_mc_engine_if.sv
// fir_axis_if: AXI-Stream sample channel with the channel index carried on tuser.
interface fir_axis_if #(parameter int WIDTH = 16, parameter int CHW = 1);
   logic signed [WIDTH-1:0] tdata;
   logic [CHW-1:0] tuser;
   logic tvalid;
   logic tready;
   modport master(output tdata, output tuser, output tvalid, input tready);
   modport slave(input tdata, input tuser, input tvalid, output tready);
endinterface

// File: rtl/fir_mc_engine_round_sat.sv
// fir_round_sat: round-half-up, shift by FRAC, then saturate (FIR_SAT_EN) or wrap to WIDTH.
module fir_round_sat #(
   parameter int WIDTH = 16,
   parameter int FRAC = 15,
   parameter int ACC_W = 35
)(
   input logic signed [ACC_W-1:0] acc,
   output logic signed [WIDTH-1:0] y
);
   localparam logic signed [ACC_W:0] RND = ((ACC_W + 1)'(1) << FRAC) >> 1;
   logic signed [ACC_W:0] sh;
   // One guard bit so adding the rounding constant can never overflow.
   assign sh = ((ACC_W + 1)'(acc) + RND) >>> FRAC;
`ifdef FIR_SAT_EN
   localparam logic signed [ACC_W:0] MAXV = {{(ACC_W - WIDTH + 2){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_W:0] MINV = ~MAXV;
   assign y = sh > MAXV ? WIDTH'(MAXV) : sh < MINV ? WIDTH'(MINV) : WIDTH'(sh);
`else
   assign y = WIDTH'(sh);
`endif
endmodule

// File: rtl/fir_mc_engine.sv
// fir_mc_engine: time-multiplexed multi-channel FIR, one shared MAC, runtime-loadable taps.
// Define FIR_SAT_EN to saturate the output instead of wrapping it.
module fir_mc_engine
   import fir_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CWIDTH = 16,
   parameter int NTAPS = 8,
   parameter int NCH = 2,
   parameter int FRAC = 15,
   localparam int CHW = chw(NCH),
   localparam int KW = clog2(NTAPS),
   localparam int ACC_W = acc_w(WIDTH, CWIDTH, NTAPS),
   localparam int PW = WIDTH + CWIDTH
)(
   input logic clk,
   input logic reset_n,
   fir_axis_if.slave s_axis,
   fir_axis_if.master m_axis,
   input logic coef_we,
   input logic [KW-1:0] coef_addr,
   input logic signed [CWIDTH-1:0] coef_data,
   output logic coef_ready,
   output logic busy
);
   state_t state, nxt;
   logic [CHW-1:0] ch;
   logic [KW-1:0] k;
   logic signed [ACC_W-1:0] acc;
   logic signed [PW-1:0] prod;
   logic signed [WIDTH-1:0] res;
   logic signed [WIDTH-1:0] x [NCH][NTAPS];
   // One bit wider than the port so the unity gain 1<<FRAC is representable.
   logic signed [CWIDTH:0] c [NTAPS];
   logic take, ch_ok;
   assign ch_ok = int'(s_axis.tuser) < NCH;
   assign take = state == IDLE && s_axis.tvalid;
   assign s_axis.tready = state == IDLE;
   assign coef_ready = state == IDLE;
   assign busy = state != IDLE;
   assign prod = PW'(x[ch][k]) * PW'(c[k]);
   assign m_axis.tvalid = state == OUT;
   assign m_axis.tdata = state == OUT ? res : '0;
   assign m_axis.tuser = state == OUT ? ch : '0;
   fir_round_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .ACC_W(ACC_W)) u_round_sat (.acc(acc), .y(res));
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE: nxt = take && ch_ok ? MAC : IDLE;
         MAC: nxt = k == KW'(NTAPS - 1) ? OUT : MAC;
         OUT: nxt = m_axis.tready ? IDLE : OUT;
         default: nxt = IDLE;
      endcase
   end
   // Samples on an out-of-range channel complete the handshake but are dropped here.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ch <= '0;
         k <= '0;
         acc <= '0;
         for (int i = 0; i < NCH; i++)
            for (int j = 0; j < NTAPS; j++) x[i][j] <= '0;
         for (int j = 0; j < NTAPS; j++) c[j] <= (CWIDTH + 1)'(coef_rst(j, FRAC));
      end else begin
         if (coef_ready && coef_we && int'(coef_addr) < NTAPS) c[coef_addr] <= (CWIDTH + 1)'(coef_data);
         if (take && ch_ok) begin
            ch <= s_axis.tuser;
            k <= '0;
            acc <= '0;
            x[s_axis.tuser][0] <= s_axis.tdata;
            for (int j = 1; j < NTAPS; j++) x[s_axis.tuser][j] <= x[s_axis.tuser][j-1];
         end
         if (state == MAC) begin
            acc <= acc + ACC_W'(prod);
            k <= k + KW'(1);
         end
      end
endmodule

// File: tb/tb_fir_mc_engine.sv
// tb_fir_mc_engine: directed checks on a default build (NTAPS=8, FRAC=15) and a small build (NTAPS=4, NCH=3, FRAC=0).
module tb_fir_mc_engine;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset_n;
   fir_axis_if #(.WIDTH(16), .CHW(1)) sa(), ma();
   fir_axis_if #(.WIDTH(16), .CHW(2)) sb(), mb();
   logic we_a, rdy_a, busy_a, we_b, rdy_b, busy_b;
   logic [2:0] addr_a;
   logic [1:0] addr_b;
   logic signed [15:0] cd_a, cd_b;
   int vectors = 0;
   int miscompares = 0;

   fir_mc_engine dut_a (
      .clk(clk), .reset_n(reset_n), .s_axis(sa), .m_axis(ma),
      .coef_we(we_a), .coef_addr(addr_a), .coef_data(cd_a), .coef_ready(rdy_a), .busy(busy_a));
   fir_mc_engine #(.NTAPS(4), .NCH(3), .FRAC(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .s_axis(sb), .m_axis(mb),
      .coef_we(we_b), .coef_addr(addr_b), .coef_data(cd_b), .coef_ready(rdy_b), .busy(busy_b));

   task automatic send_a(input logic u, input logic signed [15:0] d);
      @(negedge clk); sa.tvalid = 1'b1; sa.tdata = d; sa.tuser = u;
      @(negedge clk); sa.tvalid = 1'b0;
   endtask
   task automatic wait_a(output logic signed [15:0] q, output logic u, output int lat);
      lat = 1;
      while (!ma.tvalid && lat < 60) begin @(negedge clk); lat++; end
      q = ma.tdata; u = ma.tuser;
      ma.tready = 1'b1; @(negedge clk); ma.tready = 1'b0;
   endtask
   task automatic load_a(input logic [2:0] a, input logic signed [15:0] d);
      @(negedge clk); we_a = 1'b1; addr_a = a; cd_a = d;
      @(negedge clk); we_a = 1'b0;
   endtask
   task automatic send_b(input logic [1:0] u, input logic signed [15:0] d);
      @(negedge clk); sb.tvalid = 1'b1; sb.tdata = d; sb.tuser = u;
      @(negedge clk); sb.tvalid = 1'b0;
   endtask
   task automatic wait_b(output logic signed [15:0] q, output logic [1:0] u, output int lat);
      lat = 1;
      while (!mb.tvalid && lat < 60) begin @(negedge clk); lat++; end
      q = mb.tdata; u = mb.tuser;
      mb.tready = 1'b1; @(negedge clk); mb.tready = 1'b0;
   endtask
   task automatic load_b(input logic [1:0] a, input logic signed [15:0] d);
      @(negedge clk); we_b = 1'b1; addr_b = a; cd_b = d;
      @(negedge clk); we_b = 1'b0;
   endtask

   task automatic test_reset;
      vectors++;
      if ({sa.tready, rdy_a, ma.tvalid, busy_a, ma.tdata, ma.tuser} !== {4'b1100, 16'h0, 1'b0}) begin
         miscompares++; $display("FAIL reset_a got %b want 11000..0", {sa.tready, rdy_a, ma.tvalid, busy_a, ma.tdata, ma.tuser});
      end
      vectors++;
      if ({sb.tready, rdy_b, mb.tvalid, busy_b, mb.tdata, mb.tuser} !== {4'b1100, 16'h0, 2'b0}) begin
         miscompares++; $display("FAIL reset_b got %b want 11000..0", {sb.tready, rdy_b, mb.tvalid, busy_b, mb.tdata, mb.tuser});
      end
   endtask

   task automatic test_identity;
      logic signed [15:0] q; logic u; int lat;
      send_a(1'b0, 16'sd100);
      wait_a(q, u, lat);
      vectors++; if (q !== 16'sd100) begin miscompares++; $display("FAIL identity_data got %0d want 100", q); end
      vectors++; if (u !== 1'b0) begin miscompares++; $display("FAIL identity_user got %0d want 0", u); end
      vectors++; if (lat !== 9) begin miscompares++; $display("FAIL identity_latency got %0d want 9", lat); end
      vectors++;
      if ({sa.tready, ma.tvalid} !== 2'b10) begin miscompares++; $display("FAIL identity_idle got %b want 10", {sa.tready, ma.tvalid}); end
   endtask

   task automatic test_rounding;
      int din[4] = '{3, -3, -1, 1};
      int exp_q[4] = '{2, -1, 0, 1};
      logic signed [15:0] q; logic u; int lat;
      load_a(3'd0, 16'sd16384);
      for (int i = 0; i < 4; i++) begin
         send_a(1'(i), 16'(din[i]));
         wait_a(q, u, lat);
         vectors++;
         if (q !== 16'(exp_q[i]) || u !== 1'(i)) begin
            miscompares++; $display("FAIL round_%0d got %0d/ch%0d want %0d/ch%0d", i, q, u, exp_q[i], i % 2);
         end
      end
   endtask

   task automatic test_impulse;
      logic signed [15:0] q; logic [1:0] u; int lat;
      for (int i = 0; i < 4; i++) load_b(2'(i), 16'(i + 1));
      for (int i = 0; i < 4; i++) begin
         send_b(2'd0, i == 0 ? 16'sd1 : 16'sd0);
         wait_b(q, u, lat);
         vectors++;
         if (q !== 16'(i + 1) || lat !== 5) begin
            miscompares++; $display("FAIL impulse_%0d got %0d lat %0d want %0d lat 5", i, q, lat, i + 1);
         end
      end
   endtask

   task automatic test_channels;
      int ch_t[6] = '{0, 1, 0, 1, 0, 1};
      int din[6] = '{1, 5, 0, 5, 0, 5};
      int exp_q[6] = '{1, 5, 1, 10, 1, 15};
      logic signed [15:0] q; logic [1:0] u; int lat;
      for (int i = 0; i < 4; i++) load_b(2'(i), 16'sd1);
      for (int i = 0; i < 6; i++) begin
         send_b(2'(ch_t[i]), 16'(din[i]));
         wait_b(q, u, lat);
         vectors++;
         if (q !== 16'(exp_q[i]) || u !== 2'(ch_t[i])) begin
            miscompares++; $display("FAIL channel_%0d got %0d/ch%0d want %0d/ch%0d", i, q, u, exp_q[i], ch_t[i]);
         end
      end
   endtask

   task automatic test_saturation;
      logic signed [15:0] q, e0, e1; logic [1:0] u; int lat;
`ifdef FIR_SAT_EN
      e0 = 16'sd32767; e1 = -16'sd32768;
`else
      e0 = 16'sd1; e1 = -16'sd1;
`endif
      load_b(2'd0, 16'sd32767);
      for (int i = 1; i < 4; i++) load_b(2'(i), 16'sd0);
      send_b(2'd2, 16'sd32767);
      wait_b(q, u, lat);
      vectors++; if (q !== e0) begin miscompares++; $display("FAIL sat_pos got %0d want %0d", q, e0); end
      send_b(2'd2, -16'sd32767);
      wait_b(q, u, lat);
      vectors++; if (q !== e1) begin miscompares++; $display("FAIL sat_neg got %0d want %0d", q, e1); end
   endtask

   task automatic test_bad_channel;
      logic seen = 1'b0;
      @(negedge clk); sb.tvalid = 1'b1; sb.tuser = 2'd3; sb.tdata = 16'sd1000;
      vectors++; if (sb.tready !== 1'b1) begin miscompares++; $display("FAIL bad_ch_ready got %b want 1", sb.tready); end
      @(negedge clk); sb.tvalid = 1'b0;
      for (int i = 0; i < 12; i++) begin seen |= mb.tvalid | busy_b | ~sb.tready; @(negedge clk); end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL bad_ch_dropped got activity %b want 0", seen); end
   endtask

   task automatic test_coef_same_cycle;
      logic signed [15:0] q; logic [1:0] u; int lat;
      @(negedge clk);
      we_b = 1'b1; addr_b = 2'd0; cd_b = 16'sd5;
      sb.tvalid = 1'b1; sb.tuser = 2'd1; sb.tdata = 16'sd2;
      @(negedge clk); we_b = 1'b0; sb.tvalid = 1'b0;
      wait_b(q, u, lat);
      vectors++; if (q !== 16'sd10) begin miscompares++; $display("FAIL coef_first got %0d want 10", q); end
   endtask

   task automatic test_backpressure;
      logic signed [15:0] q; logic [1:0] u; int lat = 0;
      load_b(2'd0, 16'sd3);
      send_b(2'd0, 16'sd7);
      while (!mb.tvalid && lat < 60) begin @(negedge clk); lat++; end
      for (int i = 0; i < 20; i++) begin
         vectors++;
         if ({mb.tvalid, mb.tdata, mb.tuser, sb.tready, rdy_b} !== {1'b1, 16'sd21, 2'd0, 2'b00}) begin
            miscompares++; $display("FAIL stall_%0d got v%b d%0d rdy%b cr%b want v1 d21 rdy0 cr0", i, mb.tvalid, mb.tdata, sb.tready, rdy_b);
         end
         we_b = i == 5; addr_b = 2'd0; cd_b = 16'sd100;
         @(negedge clk);
      end
      we_b = 1'b0;
      mb.tready = 1'b1; @(negedge clk); mb.tready = 1'b0;
      vectors++;
      if ({mb.tvalid, sb.tready} !== 2'b01) begin miscompares++; $display("FAIL release got %b want 01", {mb.tvalid, sb.tready}); end
      send_b(2'd0, 16'sd1);
      wait_b(q, u, lat);
      vectors++; if (q !== 16'sd3) begin miscompares++; $display("FAIL coef_lockout got %0d want 3", q); end
   endtask

   task automatic test_reset_mid_mac;
      logic signed [15:0] q; logic u; logic [1:0] ub; int lat;
      send_a(1'b0, 16'sd50);
      @(negedge clk);
      vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL mac_busy got %b want 1", busy_a); end
      reset_n = 1'b0;
      #1;
      vectors++;
      if ({sa.tready, rdy_a, ma.tvalid, busy_a, ma.tdata} !== {4'b1100, 16'h0}) begin
         miscompares++; $display("FAIL mid_reset got %b want 1100 0", {sa.tready, rdy_a, ma.tvalid, busy_a, ma.tdata});
      end
      @(negedge clk); reset_n = 1'b1;
      send_a(1'b0, 16'sd7);
      wait_a(q, u, lat);
      vectors++;
      if (q !== 16'sd7 || lat !== 9) begin miscompares++; $display("FAIL post_reset_a got %0d lat %0d want 7 lat 9", q, lat); end
      load_b(2'd1, 16'sd1);
      send_b(2'd1, 16'sd9);
      wait_b(q, ub, lat);
      vectors++; if (q !== 16'sd9) begin miscompares++; $display("FAIL post_reset_b got %0d want 9", q); end
   endtask

   initial begin
      reset_n = 1'b0;
      sa.tvalid = 1'b0; sa.tdata = '0; sa.tuser = '0; ma.tready = 1'b0;
      sb.tvalid = 1'b0; sb.tdata = '0; sb.tuser = '0; mb.tready = 1'b0;
      we_a = 1'b0; addr_a = '0; cd_a = '0;
      we_b = 1'b0; addr_b = '0; cd_b = '0;
      repeat (3) @(negedge clk);
      test_reset;
      reset_n = 1'b1;
      test_identity;
      test_rounding;
      test_impulse;
      test_channels;
      test_saturation;
      test_bad_channel;
      test_coef_same_cycle;
      test_backpressure;
      test_reset_mid_mac;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
